// File: rtl/mmio_port_pkg.sv
// Shared definitions for the memory-mapped GPIO bank.
// Holds the per-port register indices (the low three bits of the bus word address).
package mmio_port_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_SET    = 3'd2;
  localparam logic [2:0] REG_CLR    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_MASK   = 3'd5;

endpackage

// File: rtl/mmio_port_sync.sv
// Input synchroniser for one GPIO port, plus edge detection on the synchronised value.
// Optional feature macro: GPIO_EDGE_IRQ_EN (adds the previous-value flop and edge output).
// Ports:
//   clk_i   system clock
//   rst_i   synchronous reset, active high
//   pin_i   raw external input bits of this port
//   dir_i   direction bits (1 = output, edges masked)  [GPIO_EDGE_IRQ_EN only]
//   edge_o  any-edge flags on input-direction bits       [GPIO_EDGE_IRQ_EN only]
//   sync_o  pin_i delayed through SYNC_STAGES flops
module mmio_port_sync
  import mmio_port_pkg::*;
#(
  parameter int unsigned PORT_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PORT_W-1:0] pin_i,
`ifdef GPIO_EDGE_IRQ_EN
  input  logic [PORT_W-1:0] dir_i,
  output logic [PORT_W-1:0] edge_o,
`endif
  output logic [PORT_W-1:0] sync_o
);

  logic [PORT_W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

`ifdef GPIO_EDGE_IRQ_EN
  // prev_q resets to 0, so inputs already high at reset report a rising edge once synchronised.
  logic [PORT_W-1:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= sync_o;
  end

  assign edge_o = (sync_o ^ prev_q) & ~dir_i;
`endif

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped GPIO bank: NUM_PORTS ports of PORT_W bits with per-bit direction,
// synchronised inputs, atomic set/clear and optional edge interrupts.
// Optional feature macro: GPIO_EDGE_IRQ_EN (STATUS/MASK registers and irq).
// Address: bus_addr = {port_idx, reg_idx[2:0]}; reg 0 DATA, 1 DIR, 2 SET, 3 CLR,
// 4 STATUS (W1C), 5 MASK; unused registers and absent ports read 0, ignore writes.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bus_sel, bus_we           access strobe and write enable
//   bus_addr, bus_wdata       word address and write data
//   bus_rdata, bus_rvalid     registered read data, one-cycle valid pulse after a read
//   pin_in                    external inputs, port p at [p*PORT_W +: PORT_W]
//   pin_out, pin_oe           output register and direction register (1 = drive)
//   irq                       registered OR of status & mask (0 when feature absent)
module mmio_port_bank
  import mmio_port_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned PORT_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW         = $clog2(NUM_PORTS) + 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bus_sel,
  input  logic                        bus_we,
  input  logic [AW-1:0]               bus_addr,
  input  logic [PORT_W-1:0]           bus_wdata,
  output logic [PORT_W-1:0]           bus_rdata,
  output logic                        bus_rvalid,
  input  logic [NUM_PORTS*PORT_W-1:0] pin_in,
  output logic [NUM_PORTS*PORT_W-1:0] pin_out,
  output logic [NUM_PORTS*PORT_W-1:0] pin_oe,
  output logic                        irq
);

  logic [PORT_W-1:0] out_q [NUM_PORTS];
  logic [PORT_W-1:0] out_d [NUM_PORTS];
  logic [PORT_W-1:0] dir_q [NUM_PORTS];
  logic [PORT_W-1:0] dir_d [NUM_PORTS];
  logic [PORT_W-1:0] sync_in [NUM_PORTS];
  logic [PORT_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  logic [2:0]  reg_idx;
  int unsigned port_idx;
  logic        port_ok, wr_en, rd_en;

  assign reg_idx  = bus_addr[2:0];
  assign port_idx = 32'(bus_addr >> 3);
  assign port_ok  = port_idx < NUM_PORTS;
  assign wr_en    = bus_sel & bus_we & port_ok;
  assign rd_en    = bus_sel & ~bus_we;

`ifdef GPIO_EDGE_IRQ_EN
  logic [PORT_W-1:0] edge_s   [NUM_PORTS];
  logic [PORT_W-1:0] status_q [NUM_PORTS];
  logic [PORT_W-1:0] status_d [NUM_PORTS];
  logic [PORT_W-1:0] mask_q   [NUM_PORTS];
  logic [PORT_W-1:0] mask_d   [NUM_PORTS];
  logic              irq_q, irq_d;
`endif

  for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
    mmio_port_sync #(
      .PORT_W      (PORT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk_i  (clk),
      .rst_i  (rst),
      .pin_i  (pin_in[p*PORT_W +: PORT_W]),
`ifdef GPIO_EDGE_IRQ_EN
      .dir_i  (dir_q[p]),
      .edge_o (edge_s[p]),
`endif
      .sync_o (sync_in[p])
    );

    assign pin_out[p*PORT_W +: PORT_W] = out_q[p];
    assign pin_oe[p*PORT_W +: PORT_W]  = dir_q[p];
  end

  // Register write decode.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      out_d[p] = out_q[p];
      dir_d[p] = dir_q[p];
`ifdef GPIO_EDGE_IRQ_EN
      status_d[p] = status_q[p] | edge_s[p];
      mask_d[p]   = mask_q[p];
`endif
      if (wr_en && port_idx == p) begin
        case (reg_idx)
          REG_DATA: out_d[p] = bus_wdata;
          REG_DIR:  dir_d[p] = bus_wdata;
          REG_SET:  out_d[p] = out_q[p] | bus_wdata;
          REG_CLR:  out_d[p] = out_q[p] & ~bus_wdata;
`ifdef GPIO_EDGE_IRQ_EN
          // A new edge in the clear cycle keeps its bit set.
          REG_STATUS: status_d[p] = (status_q[p] & ~bus_wdata) | edge_s[p];
          REG_MASK:   mask_d[p]   = bus_wdata;
`endif
          default: ;
        endcase
      end
    end
  end

  // Read mux: pick the addressed port's registers, then the register.
  logic [PORT_W-1:0] sel_out, sel_dir, sel_sync;
`ifdef GPIO_EDGE_IRQ_EN
  logic [PORT_W-1:0] sel_status, sel_mask;
`endif

  always_comb begin
    sel_out  = '0;
    sel_dir  = '0;
    sel_sync = '0;
`ifdef GPIO_EDGE_IRQ_EN
    sel_status = '0;
    sel_mask   = '0;
`endif
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (port_idx == p) begin
        sel_out  = out_q[p];
        sel_dir  = dir_q[p];
        sel_sync = sync_in[p];
`ifdef GPIO_EDGE_IRQ_EN
        sel_status = status_q[p];
        sel_mask   = mask_q[p];
`endif
      end
    end

    rdata_d = '0;
    if (port_ok) begin
      case (reg_idx)
        REG_DATA: rdata_d = (sel_dir & sel_out) | (~sel_dir & sel_sync);
        REG_DIR:  rdata_d = sel_dir;
`ifdef GPIO_EDGE_IRQ_EN
        REG_STATUS: rdata_d = sel_status;
        REG_MASK:   rdata_d = sel_mask;
`endif
        default: rdata_d = '0;
      endcase
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  always_comb begin
    irq_d = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) irq_d = irq_d | (|(status_q[p] & mask_q[p]));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        out_q[p] <= '0;
        dir_q[p] <= '0;
`ifdef GPIO_EDGE_IRQ_EN
        status_q[p] <= '0;
        mask_q[p]   <= '0;
`endif
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef GPIO_EDGE_IRQ_EN
      irq_q <= 1'b0;
`endif
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        out_q[p] <= out_d[p];
        dir_q[p] <= dir_d[p];
`ifdef GPIO_EDGE_IRQ_EN
        status_q[p] <= status_d[p];
        mask_q[p]   <= mask_d[p];
`endif
      end
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
`ifdef GPIO_EDGE_IRQ_EN
      irq_q <= irq_d;
`endif
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
`ifdef GPIO_EDGE_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
